// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdio_pkg
// Description : Shared Clause-22 MDIO frame constants and FSM state type.
// Revision    : 1.0
// ============================================================================
package mdio_pkg;

  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] ST_PATTERN = 2'b01;

  localparam logic [5:0] HDR_END   = 6'd14;
  localparam logic [5:0] TA_END    = 6'd16;
  localparam logic [5:0] FRAME_LEN = 6'd32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ST   = 3'd1,
    HDR  = 3'd2,
    SKIP = 3'd3,
    WTA  = 3'd4,
    WDAT = 3'd5,
    RTA  = 3'd6,
    RDAT = 3'd7
  } mdio_state_t;

endpackage
`default_nettype wire

// File: rtl/mdio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : mdio_sync_edge
// Description : 2-flop synchronizer for MDC and a data line, plus MDC edge pulses.
// Revision    : 1.0
// ============================================================================
module mdio_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_mdc,
  input  logic i_dat,
  output logic o_dat,
  output logic o_rise,
  output logic o_fall
);

  // Both lines share one chain so data and clock see identical delay.
  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= {i_dat, i_mdc};
      r_sync <= r_meta;
      r_prev <= r_sync[0];
    end
  end

  assign o_dat  = r_sync[1];
  assign o_rise = r_sync[0] & ~r_prev;
  assign o_fall = ~r_sync[0] & r_prev;

endmodule
`default_nettype wire

// File: rtl/mdio_peripheral_if.sv
`default_nettype none
// ============================================================================
// Module      : mdio_peripheral_if
// Description : PHY-side Clause-22 MDIO frame decoder driving a register file.
// Revision    : 1.0
// ============================================================================
module mdio_peripheral_if
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  output logic        MDIO_IN,
  output logic        PHY_OE,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  input  logic [15:0] RD_DATA
);

  logic w_mdio, w_rise, w_fall;

  mdio_sync_edge u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_mdc  (MDC),
    .i_dat  (MDIO_OUT),
    .o_dat  (w_mdio),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  mdio_state_t r_state, w_state_nxt;
  logic [5:0]  r_bit, w_bit_nxt, w_bit_inc;
  logic [14:0] r_shift, w_shift_nxt;
  logic [15:0] r_tx, w_tx_nxt;
  logic [4:0]  r_regad, w_regad_nxt;
  logic [4:0]  r_addr, w_addr_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic        r_stb, w_stb_nxt;
  logic        r_oe, w_oe_nxt;
  logic        r_mdo, w_mdo_nxt;
  logic [11:0] w_hdr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= '0;
      r_regad <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_stb   <= 1'b0;
      r_oe    <= 1'b0;
      r_mdo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_regad <= w_regad_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_stb   <= w_stb_nxt;
      r_oe    <= w_oe_nxt;
      r_mdo   <= w_mdo_nxt;
    end
  end

  // r_bit holds the number of the most recently sampled frame bit.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_regad_nxt = r_regad;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_stb_nxt   = 1'b0;
    w_oe_nxt    = r_oe;
    w_mdo_nxt   = r_mdo;
    w_bit_inc   = r_bit + 6'd1;
    w_hdr       = {r_shift[10:0], w_mdio};

    if (w_rise) begin
      w_bit_nxt = w_bit_inc;
      case (r_state)
        IDLE: begin
          w_bit_nxt = (w_mdio == ST_PATTERN[1]) ? 6'd1 : 6'd0;
          if (w_mdio == ST_PATTERN[1]) w_state_nxt = ST;
        end
        ST: begin
          w_bit_nxt = (w_mdio == ST_PATTERN[0]) ? 6'd2 : 6'd1;
          if (w_mdio == ST_PATTERN[0]) w_state_nxt = HDR;
        end
        HDR: begin
          w_shift_nxt = {r_shift[13:0], w_mdio};
          if (w_bit_inc == HDR_END) begin
            w_regad_nxt = w_hdr[4:0];
            if (w_hdr[9:5] != PHY_ADDR) begin
              w_state_nxt = SKIP;
            end else if (w_hdr[11:10] == OP_WRITE) begin
              w_state_nxt = WTA;
            end else if (w_hdr[11:10] == OP_READ) begin
              w_addr_nxt  = w_hdr[4:0];
              w_state_nxt = RTA;
            end else begin
              w_state_nxt = SKIP;
            end
          end
        end
        SKIP: begin
          if (w_bit_inc == FRAME_LEN) begin
            w_state_nxt = IDLE;
            w_bit_nxt   = '0;
          end
        end
        WTA: begin
          if (w_bit_inc == TA_END) w_state_nxt = WDAT;
        end
        WDAT: begin
          w_shift_nxt = {r_shift[13:0], w_mdio};
          if (w_bit_inc == FRAME_LEN) begin
            w_wdata_nxt = {r_shift, w_mdio};
            w_addr_nxt  = r_regad;
            w_stb_nxt   = 1'b1;
            w_state_nxt = IDLE;
            w_bit_nxt   = '0;
          end
        end
        RTA, RDAT: ;
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_fall) begin
      case (r_state)
        RTA: begin
          if (r_bit == HDR_END) begin
            w_tx_nxt = RD_DATA;
          end else if (r_bit == HDR_END + 6'd1) begin
            w_oe_nxt    = 1'b1;
            w_mdo_nxt   = 1'b0;
            w_state_nxt = RDAT;
          end
        end
        RDAT: begin
          if (r_bit == FRAME_LEN) begin
            w_oe_nxt    = 1'b0;
            w_mdo_nxt   = 1'b0;
            w_state_nxt = IDLE;
            w_bit_nxt   = '0;
          end else begin
            w_mdo_nxt = r_tx[15];
            w_tx_nxt  = {r_tx[14:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign MDIO_IN = r_mdo;
  assign PHY_OE  = r_oe;
  assign ADDR    = r_addr;
  assign WR_DATA = r_wdata;
  assign WR_STB  = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_mdio_peripheral_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdio_peripheral_if
// Description : Scoreboard bench for mdio_peripheral_if with directed and random frames.
// Revision    : 1.0
// ============================================================================
module tb_mdio_peripheral_if;

  localparam logic [4:0] TB_PHY = 5'd9;
  localparam int         HALF   = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MDC = 1'b0;
  logic        MDIO_OUT = 1'b1;
  logic        MDIO_IN;
  logic        PHY_OE;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;
  logic [15:0] RD_DATA;

  always #5 clk = ~clk;

  mdio_peripheral_if #(.PHY_ADDR(TB_PHY)) dut (
    .clk      (clk),
    .reset    (reset),
    .MDC      (MDC),
    .MDIO_OUT (MDIO_OUT),
    .MDIO_IN  (MDIO_IN),
    .PHY_OE   (PHY_OE),
    .ADDR     (ADDR),
    .WR_DATA  (WR_DATA),
    .WR_STB   (WR_STB),
    .RD_DATA  (RD_DATA)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    bit          aborted;
  } rd_t;

  logic [20:0] q_wr[$];
  rd_t         q_rd[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Register file seen by the DUT; written by the monitor on WR_STB.
  logic [15:0] regfile[32];
  assign RD_DATA = regfile[ADDR];

  // Reference model state.
  logic [15:0] model_regs[32];
  logic [4:0]  model_addr;
  logic [15:0] model_wdata;

  // Bits the controller captured on MDC rises while PHY_OE was high.
  logic [31:0] rx_sr = '0;
  int          rx_total = 0;

  function automatic logic [15:0] init_val(input int i);
    return (i == 1) ? 16'hFFFF : 16'(i * 256);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send_bit(input logic b);
    MDIO_OUT = b;
    repeat (HALF) @(negedge clk);
    if (PHY_OE) begin
      rx_sr = {rx_sr[30:0], MDIO_IN};
      rx_total++;
    end
    MDC = 1'b1;
    repeat (HALF) @(negedge clk);
    MDC = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] regad,
                            input logic [15:0] data, input int pre, input int abort_at);
    logic [31:0] f;
    bit match, aborted;
    rd_t r;
    match = (phy == TB_PHY) && (op == 2'b01 || op == 2'b10);
    f = {2'b01, op, phy, regad, 18'h3FFFF};
    if (op != 2'b10) f[17:0] = {2'b10, data};
    if (match && op == 2'b01) q_wr.push_back({regad, data});
    if (match && op == 2'b10) begin
      r.addr = regad; r.data = model_regs[regad]; r.aborted = (abort_at != 0);
      q_rd.push_back(r);
    end
    for (int i = 0; i < pre; i++) send_bit(1'b1);
    aborted = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      if (abort_at != 0 && n > abort_at) begin
        aborted = 1'b1;
        break;
      end
      send_bit(f[32 - n]);
    end
    MDIO_OUT = 1'b1;
    if (aborted) begin
      reset = 1'b1;
      @(negedge clk);
      check("abort_oe_next_clk", {31'd0, PHY_OE}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_addr  = '0;
      model_wdata = '0;
      @(negedge clk);
    end else begin
      if (match && op == 2'b01) begin
        model_addr = regad; model_wdata = data; model_regs[regad] = data;
      end
      if (match && op == 2'b10) model_addr = regad;
      repeat (4) @(negedge clk);
    end
    check("frame_addr", {27'd0, ADDR}, {27'd0, model_addr});
    check("frame_wdata", {16'd0, WR_DATA}, {16'd0, model_wdata});
    check("frame_oe_low", {31'd0, PHY_OE}, 32'd0);
  endtask

  // Monitor: pops expectations whenever the DUT strobes a write or opens a read.
  initial begin
    rd_t cur;
    logic [20:0] e;
    logic prev_oe;
    int start;
    for (int i = 0; i < 32; i++) regfile[i] = init_val(i);
    prev_oe = 1'b0;
    start = 0;
    cur.addr = '0; cur.data = '0; cur.aborted = 1'b0;
    forever begin
      @(negedge clk);
      if (WR_STB) begin
        check("wr_expected", {31'd0, q_wr.size() != 0}, 32'd1);
        if (q_wr.size() != 0) begin
          e = q_wr.pop_front();
          check("wr_addr", {27'd0, ADDR}, {27'd0, e[20:16]});
          check("wr_data", {16'd0, WR_DATA}, {16'd0, e[15:0]});
        end
        regfile[ADDR] = WR_DATA;
      end
      if (PHY_OE && !prev_oe) begin
        check("rd_expected", {31'd0, q_rd.size() != 0}, 32'd1);
        if (q_rd.size() != 0) cur = q_rd.pop_front();
        check("rd_addr", {27'd0, ADDR}, {27'd0, cur.addr});
        start = rx_total;
      end
      if (!PHY_OE && prev_oe) begin
        if (cur.aborted) begin
          check("rd_abort_by_reset", {31'd0, reset}, 32'd1);
        end else begin
          check("rd_bit_times", rx_total - start, 32'd17);
          check("rd_serial", {15'd0, rx_sr[16:0]}, {16'd0, cur.data});
        end
      end
      prev_oe = PHY_OE;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] op;
    logic [4:0] phy;
    for (int i = 0; i < 32; i++) model_regs[i] = init_val(i);
    model_addr  = '0;
    model_wdata = '0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mdio_in", {31'd0, MDIO_IN}, 32'd0);
    check("rst_phy_oe", {31'd0, PHY_OE}, 32'd0);
    check("rst_addr", {27'd0, ADDR}, 32'd0);
    check("rst_wr_data", {16'd0, WR_DATA}, 32'd0);
    check("rst_wr_stb", {31'd0, WR_STB}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    send_frame(2'b01, TB_PHY, 5'd5, 16'hA5A5, 32, 0);
    send_frame(2'b10, TB_PHY, 5'd3, 16'h0000, 32, 0);
    send_frame(2'b01, TB_PHY + 5'd1, 5'd10, 16'h1111, 4, 0);
    send_frame(2'b11, TB_PHY, 5'd6, 16'h5555, 2, 0);
    send_frame(2'b01, TB_PHY, 5'd7, 16'h1234, 0, 0);
    send_frame(2'b10, TB_PHY, 5'd3, 16'h0000, 3, 20);
    send_frame(2'b10, TB_PHY, 5'd1, 16'h0000, 4, 0);
    send_frame(2'b01, TB_PHY, 5'd2, 16'hBEEF, 3, 0);
    send_frame(2'b10, TB_PHY, 5'd2, 16'h0000, 0, 0);

    for (int k = 0; k < 24; k++) begin
      op  = 2'($urandom_range(0, 3));
      phy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : TB_PHY;
      send_frame(op, phy, 5'($urandom), 16'($urandom), $urandom_range(0, 3), 0);
    end

    repeat (20) @(negedge clk);
    check("wr_queue_drained", q_wr.size(), 32'd0);
    check("rd_queue_drained", q_rd.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
